// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared types and constants for the 4-peg, 4-colour Mastermind solver.
package mastermind_pkg;
    localparam int PEGS = 4;
    localparam int COLOR_W = 2;
    typedef logic [PEGS*COLOR_W-1:0] code_t;
    typedef struct packed {
        logic [2:0] correct;
        logic [2:0] wrong;
    } fb_t;
    typedef struct packed {
        code_t guess;
        fb_t   fb;
    } hist_t;
    typedef enum logic [2:0] {IDLE, SEARCH, ISSUE, WAIT_FB, DONE, FAIL} state_t;
endpackage

// File: rtl/mastermind_solver_peg_score.sv
// peg_score: combinational Mastermind score of code a against code b.
module peg_score
    import mastermind_pkg::*;
(
    input  code_t a,
    input  code_t b,
    output fb_t   fb
);
    logic [2:0] na [1<<COLOR_W];
    logic [2:0] nb [1<<COLOR_W];
    logic [2:0] correct, common;
    always_comb begin
        correct = '0;
        common = '0;
        for (int c = 0; c < (1 << COLOR_W); c++) begin
            na[c] = '0;
            nb[c] = '0;
        end
        for (int p = 0; p < PEGS; p++) begin
            correct = correct + 3'(a[p*COLOR_W +: COLOR_W] == b[p*COLOR_W +: COLOR_W]);
            na[a[p*COLOR_W +: COLOR_W]] = na[a[p*COLOR_W +: COLOR_W]] + 3'd1;
            nb[b[p*COLOR_W +: COLOR_W]] = nb[b[p*COLOR_W +: COLOR_W]] + 3'd1;
        end
        // Shared colours per colour is the smaller of the two counts; exact hits are a subset.
        for (int c = 0; c < (1 << COLOR_W); c++)
            common = common + ((na[c] < nb[c]) ? na[c] : nb[c]);
        fb.correct = correct;
        fb.wrong = common - correct;
    end
endmodule

// File: rtl/mastermind_solver.sv
// mastermind_solver: exhaustive-consistent Mastermind codebreaker; each guess is the
// lowest code consistent with all stored feedback, tested one history entry per cycle.
module mastermind_solver
    import mastermind_pkg::*;
#(
    parameter int HIST_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output code_t      guess,
    output logic       guess_valid,
    input  logic       guess_ready,
    input  logic       fb_valid,
    input  logic [2:0] fb_correct,
    input  logic [2:0] fb_wrong,
    output logic       busy,
    output logic       solved,
    output logic       fail,
    output logic [3:0] tries
);
    localparam int IW = $clog2(HIST_DEPTH);
    state_t     state, state_nx;
    code_t      cand;
    logic [3:0] h, count;
    hist_t      hist [HIST_DEPTH];
    hist_t      hcur;
    fb_t        sc;
    logic       match, last, hist_full;
    assign hcur = hist[h[IW-1:0]];
    peg_score u_score (.a(cand), .b(hcur.guess), .fb(sc));
    assign match = count == 4'd0 || sc == hcur.fb;
    assign last = count == 4'd0 || h == count - 4'd1;
    assign hist_full = count + 4'd1 == 4'(HIST_DEPTH);
    assign guess_valid = state == ISSUE;
    assign busy = state inside {SEARCH, ISSUE, WAIT_FB};
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            SEARCH:  state_nx = !match ? (cand == 8'hFF ? FAIL : SEARCH) : (last ? ISSUE : SEARCH);
            ISSUE:   state_nx = guess_ready ? WAIT_FB : ISSUE;
            WAIT_FB: state_nx = !fb_valid ? WAIT_FB : fb_correct == 3'd4 ? DONE :
                                (hist_full || guess == 8'hFF) ? FAIL : SEARCH;
            default: ;
        endcase
        if (start) state_nx = SEARCH;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            guess <= '0;
            cand <= '0;
            h <= '0;
            count <= '0;
            tries <= '0;
            solved <= 1'b0;
            fail <= 1'b0;
        end else if (start) begin
            cand <= '0;
            h <= '0;
            count <= '0;
            tries <= '0;
            solved <= 1'b0;
            fail <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (!match) begin
                        cand <= cand + 8'd1;
                        h <= '0;
                        if (cand == 8'hFF) fail <= 1'b1;
                    end else if (last) begin
                        guess <= cand;
                    end else begin
                        h <= h + 4'd1;
                    end
                end
                ISSUE: if (guess_ready) tries <= tries + 4'd1;
                WAIT_FB: begin
                    if (fb_valid) begin
                        if (fb_correct == 3'd4) begin
                            solved <= 1'b1;
                        end else begin
                            hist[count[IW-1:0]] <= hist_t'({guess, fb_correct, fb_wrong});
                            count <= count + 4'd1;
                            h <= '0;
                            // Codes below the last guess were already ruled out.
                            if (hist_full || guess == 8'hFF) fail <= 1'b1;
                            else cand <= guess + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
